// File: rtl/ex_alu_rs_pkg.sv
// Shared definitions for ALU execution units: op encodings, tag sentinel and
// default-width word/tag/address types.
package ex_alu_rs_pkg;

  localparam int UNLOCKED = 0;

  localparam int XLEN_DEF  = 32;
  localparam int TAG_W_DEF = 4;
  localparam int RA_W_DEF  = 5;

  typedef logic [XLEN_DEF-1:0]  word_t;
  typedef logic [TAG_W_DEF-1:0] regtag_t;
  typedef logic [RA_W_DEF-1:0]  regaddr_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SRL  = 4'd3,
    OP_SRA  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTU = 4'd6,
    OP_XOR  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9,
    OP_LUI  = 4'd10
  } sinst_t;

endpackage

// File: rtl/ex_alu_rs_core.sv
// Purely combinational integer ALU: op, x, y -> result with XLEN wraparound.
// Undefined op codes produce zero.
module ex_alu_core
  import ex_alu_rs_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  output logic [XLEN-1:0] result
);

  localparam int SH_W = $clog2(XLEN);

  logic signed [XLEN-1:0] sx;
  logic signed [XLEN-1:0] sy;
  logic        [SH_W-1:0] sh;

  assign sx = x;
  assign sy = y;
  assign sh = y[SH_W-1:0];

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = x + y;
      OP_SUB:  result = x - y;
      OP_SLL:  result = x << sh;
      OP_SRL:  result = x >> sh;
      OP_SRA:  result = sx >>> sh;
      OP_SLT:  result = {{(XLEN-1){1'b0}}, (sx < sy)};
      OP_SLTU: result = {{(XLEN-1){1'b0}}, (x < y)};
      OP_XOR:  result = x ^ y;
      OP_OR:   result = x | y;
      OP_AND:  result = x & y;
      OP_LUI:  result = x;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/ex_alu_rs.sv
// ALU execution unit: DEPTH-entry reservation station snooping the CDB, firing
// the lowest-index ready entry into a registered valid/ready writeback port.
module ex_alu_rs
  import ex_alu_rs_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int RA_W  = 5,
  parameter int OP_W  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       iss_valid,
  output logic                       iss_ready,
  input  logic [OP_W-1:0]            iss_op,
  input  logic [TAG_W-1:0]           iss_tagx,
  input  logic [TAG_W-1:0]           iss_tagy,
  input  logic [XLEN-1:0]            iss_datax,
  input  logic [XLEN-1:0]            iss_datay,
  input  logic [TAG_W-1:0]           iss_tagw,
  input  logic [RA_W-1:0]            iss_target,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [XLEN-1:0]            cdb_data,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [TAG_W-1:0]           wb_tagw,
  output logic [RA_W-1:0]            wb_target,
  output logic [XLEN-1:0]            wb_data,
  output logic [$clog2(DEPTH+1)-1:0] free_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(UNLOCKED);

  logic [DEPTH-1:0] valid, valid_nxt, rdy_vec;
  logic [OP_W-1:0]  e_op     [DEPTH];
  logic [TAG_W-1:0] e_tagx   [DEPTH];
  logic [TAG_W-1:0] e_tagy   [DEPTH];
  logic [XLEN-1:0]  e_datax  [DEPTH];
  logic [XLEN-1:0]  e_datay  [DEPTH];
  logic [TAG_W-1:0] e_tagw   [DEPTH];
  logic [RA_W-1:0]  e_target [DEPTH];

  logic [IDX_W-1:0] free_idx, fire_idx;
  logic             fire, issue, hit_x, hit_y;
  logic [XLEN-1:0]  alu_result;

  function automatic logic [IDX_W-1:0] pick_low(input logic [DEPTH-1:0] v);
    pick_low = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (v[i]) pick_low = IDX_W'(i);
    end
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
    popcount = '0;
    for (int i = 0; i < DEPTH; i++) popcount = popcount + CNT_W'(v[i]);
  endfunction

  always_comb begin
    rdy_vec = '0;
    for (int i = 0; i < DEPTH; i++)
      rdy_vec[i] = valid[i] && (e_tagx[i] == NO_TAG) && (e_tagy[i] == NO_TAG);
  end

  assign iss_ready = (free_cnt != '0);
  assign free_idx  = pick_low(~valid);
  assign fire_idx  = pick_low(rdy_vec);
  assign fire      = (!wb_valid || wb_ready) && (|rdy_vec);
  assign issue     = iss_valid && iss_ready;
  // Forward a same-cycle broadcast into the issuing entry so no wakeup is lost.
  assign hit_x     = cdb_valid && (iss_tagx != NO_TAG) && (iss_tagx == cdb_tag);
  assign hit_y     = cdb_valid && (iss_tagy != NO_TAG) && (iss_tagy == cdb_tag);

  always_comb begin
    valid_nxt = valid;
    if (fire)  valid_nxt[fire_idx] = 1'b0;
    if (issue) valid_nxt[free_idx] = 1'b1;
  end

  ex_alu_core #(.XLEN(XLEN), .OP_W(OP_W)) u_core (
    .op     (e_op[fire_idx]),
    .x      (e_datax[fire_idx]),
    .y      (e_datay[fire_idx]),
    .result (alu_result)
  );

  // Entry payload: CDB snoop, then dispatch write (validity gates all use).
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (cdb_valid && (e_tagx[i] != NO_TAG) && (e_tagx[i] == cdb_tag)) begin
        e_datax[i] <= cdb_data;
        e_tagx[i]  <= NO_TAG;
      end
      if (cdb_valid && (e_tagy[i] != NO_TAG) && (e_tagy[i] == cdb_tag)) begin
        e_datay[i] <= cdb_data;
        e_tagy[i]  <= NO_TAG;
      end
    end
    if (issue) begin
      e_op[free_idx]     <= iss_op;
      e_tagx[free_idx]   <= hit_x ? NO_TAG : iss_tagx;
      e_tagy[free_idx]   <= hit_y ? NO_TAG : iss_tagy;
      e_datax[free_idx]  <= hit_x ? cdb_data : iss_datax;
      e_datay[free_idx]  <= hit_y ? cdb_data : iss_datay;
      e_tagw[free_idx]   <= iss_tagw;
      e_target[free_idx] <= iss_target;
    end
  end

  // Control and writeback register stage.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      valid     <= '0;
      free_cnt  <= CNT_W'(DEPTH);
      wb_valid  <= 1'b0;
      wb_tagw   <= '0;
      wb_target <= '0;
      wb_data   <= '0;
    end else begin
      valid    <= valid_nxt;
      free_cnt <= CNT_W'(DEPTH) - popcount(valid_nxt);
      if (fire) begin
        wb_valid  <= 1'b1;
        wb_tagw   <= e_tagw[fire_idx];
        wb_target <= e_target[fire_idx];
        wb_data   <= alu_result;
      end else if (wb_ready) begin
        wb_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_alu_rs.sv
// Directed bench for ex_alu_rs: expected writebacks are queued at issue and a
// separate monitor pops and compares them whenever a result is consumed.
module tb_ex_alu_rs;
  import ex_alu_rs_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, iss_valid, iss_ready;
  logic [3:0]  iss_op, iss_tagx, iss_tagy, iss_tagw;
  logic [31:0] iss_datax, iss_datay;
  logic [4:0]  iss_target;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        wb_valid, wb_ready;
  logic [3:0]  wb_tagw;
  logic [4:0]  wb_target;
  logic [31:0] wb_data;
  logic [2:0]  free_cnt;

  ex_alu_rs dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_tagx(iss_tagx), .iss_tagy(iss_tagy), .iss_datax(iss_datax),
    .iss_datay(iss_datay), .iss_tagw(iss_tagw), .iss_target(iss_target),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tagw(wb_tagw),
    .wb_target(wb_target), .wb_data(wb_data), .free_cnt(free_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  tagw;
    logic [4:0]  target;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: one result is consumed at each edge where wb_valid && wb_ready.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && wb_valid && wb_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_wb: got data %h, required no result", wb_data);
        end else begin
          mon_e = sb.pop_front();
          check("wb_data",   wb_data,          mon_e.data);
          check("wb_tagw",   32'(wb_tagw),     32'(mon_e.tagw));
          check("wb_target", 32'(wb_target),   32'(mon_e.target));
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] tx, input logic [3:0] ty,
                       input logic [31:0] dx, input logic [31:0] dy,
                       input logic [3:0] tw, input logic [4:0] tg,
                       input logic [31:0] expd, output bit acc);
    iss_valid = 1'b1; iss_op = op; iss_tagx = tx; iss_tagy = ty;
    iss_datax = dx; iss_datay = dy; iss_tagw = tw; iss_target = tg;
    @(negedge clk);
    acc = iss_ready && !flush;
    if (acc) sb.push_back('{tw, tg, expd});
    tick();
    iss_valid = 1'b0;
  endtask

  task automatic drain;
    int k;
    k = 0;
    while ((sb.size() != 0 || wb_valid) && k < 30) begin
      tick();
      k++;
    end
    if (sb.size() != 0 || wb_valid) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d results outstanding, required 0", sb.size());
    end
  endtask

  bit acc;
  logic [31:0] held;

  initial begin
    rst_n = 1'b0; flush = 1'b0; iss_valid = 1'b0; iss_op = '0; iss_tagx = '0;
    iss_tagy = '0; iss_datax = '0; iss_datay = '0; iss_tagw = '0; iss_target = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; wb_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("rst_wb_valid",  32'(wb_valid),  32'd0);
    check("rst_free_cnt",  32'(free_cnt),  32'd4);
    check("rst_iss_ready", 32'(iss_ready), 32'd1);
    check("rst_wb_data",   wb_data,        32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Ready issue: result visible one cycle after the entry is written.
    issue(OP_ADD, 4'd0, 4'd0, 32'd5, 32'd7, 4'd3, 5'd9, 32'd12, acc);
    tick();
    @(negedge clk);
    check("lat_wb_valid", 32'(wb_valid), 32'd1);
    check("lat_wb_data",  wb_data,       32'd12);
    tick();
    drain();

    // Arithmetic edge cases and the remaining ops.
    issue(OP_SRA,  4'd0, 4'd0, 32'h8000_0000, 32'd31, 4'd1, 5'd1,  32'hFFFF_FFFF, acc);
    issue(OP_SLT,  4'd0, 4'd0, 32'hFFFF_FFFF, 32'd1,  4'd2, 5'd2,  32'd1,         acc);
    issue(OP_SLTU, 4'd0, 4'd0, 32'hFFFF_FFFF, 32'd1,  4'd3, 5'd3,  32'd0,         acc);
    issue(OP_ADD,  4'd0, 4'd0, 32'hFFFF_FFFF, 32'd1,  4'd4, 5'd4,  32'd0,         acc);
    issue(OP_SLL,  4'd0, 4'd0, 32'd1,         32'd33, 4'd5, 5'd5,  32'd2,         acc);
    issue(OP_SRL,  4'd0, 4'd0, 32'h8000_0000, 32'd33, 4'd6, 5'd6,  32'h4000_0000, acc);
    issue(OP_SUB,  4'd0, 4'd0, 32'd3,         32'd5,  4'd7, 5'd7,  32'hFFFF_FFFE, acc);
    issue(OP_XOR,  4'd0, 4'd0, 32'h0000_F0F0, 32'h0000_FF00, 4'd8,  5'd8,  32'h0000_0FF0, acc);
    issue(OP_OR,   4'd0, 4'd0, 32'h0000_F0F0, 32'h0000_FF00, 4'd9,  5'd10, 32'h0000_FFF0, acc);
    issue(OP_AND,  4'd0, 4'd0, 32'h0000_F0F0, 32'h0000_FF00, 4'd10, 5'd11, 32'h0000_F000, acc);
    issue(OP_LUI,  4'd0, 4'd0, 32'h1234_5000, 32'd99, 4'd11, 5'd12, 32'h1234_5000, acc);
    issue(4'hF,    4'd0, 4'd0, 32'd123,       32'd45, 4'd12, 5'd13, 32'd0,         acc);
    drain();

    // Wakeup via CDB three cycles after issue.
    issue(OP_SUB, 4'd2, 4'd0, 32'd0, 32'd1, 4'd5, 5'd4, 32'd9, acc);
    tick(); tick();
    @(negedge clk);
    check("locked_no_fire", 32'(wb_valid), 32'd0);
    tick();
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'd10;
    tick();
    cdb_valid = 1'b0;
    drain();
    // Same-cycle issue and broadcast.
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'd10;
    issue(OP_SUB, 4'd2, 4'd0, 32'd0, 32'd1, 4'd6, 5'd7, 32'd9, acc);
    cdb_valid = 1'b0;
    drain();
    // One broadcast wakes both operands.
    issue(OP_ADD, 4'd3, 4'd3, 32'd0, 32'd0, 4'd7, 5'd8, 32'd42, acc);
    cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_data = 32'd21;
    tick();
    cdb_valid = 1'b0;
    drain();

    // Backpressure: occupy wb, then fill all four entries.
    wb_ready = 1'b0;
    issue(OP_ADD, 4'd0, 4'd0, 32'd1, 32'd1, 4'd1, 5'd1, 32'd2, acc);
    tick();
    for (int i = 0; i < 5; i++) begin
      issue(OP_ADD, 4'd0, 4'd0, 32'd100, 32'(i), 4'(i + 2), 5'(i + 20), 32'(100 + i), acc);
      check("full_accept", 32'(acc), (i < 4) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("full_iss_ready", 32'(iss_ready), 32'd0);
    check("full_free_cnt",  32'(free_cnt),  32'd0);
    held = wb_data;
    check("hold_first", wb_data, 32'd2);
    tick(); tick(); tick();
    @(negedge clk);
    check("hold_stable_data", wb_data,        held);
    check("hold_stable_tagw", 32'(wb_tagw),   32'd1);
    check("hold_valid",       32'(wb_valid),  32'd1);
    tick();
    wb_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("throughput_valid", 32'(wb_valid), 32'd1);
    end
    tick();
    drain();

    // Reset in the middle of traffic.
    wb_ready = 1'b0;
    issue(OP_ADD, 4'd0, 4'd0, 32'd3, 32'd3, 4'd1, 5'd1, 32'd6, acc);
    issue(OP_ADD, 4'd0, 4'd0, 32'd4, 32'd4, 4'd2, 5'd2, 32'd8, acc);
    issue(OP_ADD, 4'd9, 4'd0, 32'd0, 32'd4, 4'd3, 5'd3, 32'd0, acc);
    rst_n = 1'b0;
    tick(); tick();
    sb.delete();
    @(negedge clk);
    check("mid_rst_wb_valid",  32'(wb_valid),  32'd0);
    check("mid_rst_free_cnt",  32'(free_cnt),  32'd4);
    check("mid_rst_iss_ready", 32'(iss_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    wb_ready = 1'b1;
    tick();

    // Flush with a held result and three locked entries.
    wb_ready = 1'b0;
    issue(OP_ADD, 4'd0, 4'd0, 32'd4, 32'd4, 4'd1, 5'd1, 32'd8, acc);
    tick();
    for (int i = 0; i < 3; i++)
      issue(OP_ADD, 4'd6, 4'd0, 32'd0, 32'(i), 4'(i + 2), 5'(i + 2), 32'd0, acc);
    @(negedge clk);
    check("pre_flush_wb_valid", 32'(wb_valid), 32'd1);
    check("pre_flush_free_cnt", 32'(free_cnt), 32'd1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_wb_valid", 32'(wb_valid), 32'd0);
    check("flush_free_cnt", 32'(free_cnt), 32'd4);
    check("flush_wb_data",  wb_data,       32'd0);
    tick();
    wb_ready = 1'b1;
    cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_data = 32'd1;
    tick();
    cdb_valid = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    check("post_flush_no_result", 32'(wb_valid), 32'd0);
    check("post_flush_free_cnt",  32'(free_cnt), 32'd4);
    tick();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required $finish before timeout");
    $fatal(1, "timeout");
  end

endmodule
